convolution_engine: RTL and testbench

//  Consumer end of the kernel coefficient interface. Takes a 3x3 RGB565 pixel window

---
 rtl/conv_pkg.sv | 13 +
 rtl/conv_if.sv | 33 +++
 rtl/conv_channel.sv | 71 +++++++
 rtl/convolution_engine.sv | 150 +++++++++++++++
 tb/tb_convolution_engine.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared types and limits for the 3x3 RGB565 convolution datapath.
package conv_pkg;

  typedef logic [15:0]                  rgb565_t;
  typedef logic [2:0][2:0][15:0]        window_t;
  typedef logic signed [2:0][2:0][7:0]  kernel_t;

  localparam int R_MAX     = 31;
  localparam int G_MAX     = 63;
  localparam int B_MAX     = 31;
  localparam int MAX_SHIFT = 15;

endpackage

// File: rtl/conv_if.sv
// Window-in / pixel-out bundle between line buffer, kernel selector and frame writer.
interface conv_if
  import conv_pkg::*;
#(
  parameter int HRES = 320,
  parameter int VRES = 180
);
  localparam int HW = $clog2(HRES);
  localparam int VW = $clog2(VRES);

  logic                 data_in_valid;
  window_t              data_in;
  logic [HW-1:0]        hcount_in;
  logic [VW-1:0]        vcount_in;
  kernel_t              coeffs_in;
  logic signed [7:0]    shift_in;
  logic signed [7:0]    offset_in;
  logic                 data_out_valid;
  rgb565_t              data_out;
  logic [HW-1:0]        hcount_out;
  logic [VW-1:0]        vcount_out;

  modport master (
    output data_in_valid, data_in, hcount_in, vcount_in, coeffs_in, shift_in, offset_in,
    input  data_out_valid, data_out, hcount_out, vcount_out
  );

  modport slave (
    input  data_in_valid, data_in, hcount_in, vcount_in, coeffs_in, shift_in, offset_in,
    output data_out_valid, data_out, hcount_out, vcount_out
  );

endinterface

// File: rtl/conv_channel.sv
// One colour channel: 9-tap multiply, sum, arithmetic shift, bias and clamp.
module conv_channel
  import conv_pkg::*;
#(
  parameter int CW   = 5,
  parameter int MAXV = 31
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        vld_p1,
  input  logic [2:0][2:0][CW-1:0]     pix,
  input  kernel_t                     coef,
  input  logic [3:0]                  sh_p1,
  input  logic signed [7:0]           off_p1,
  output logic [CW-1:0]               q_p2
);

  localparam logic signed [21:0] MAXS = 22'(MAXV);

  function automatic logic [CW-1:0] clamp(input logic signed [21:0] v);
    if (v[21])
      return '0;
    else if (v > MAXS)
      return CW'(MAXV);
    else
      return v[CW-1:0];
  endfunction

  logic signed [16:0] prod_p0 [3][3];
  logic signed [20:0] acc;
  logic signed [20:0] sum_p1;
  logic signed [20:0] shd;
  logic signed [21:0] biased;

  // S1: channel value zero-extended to 9b signed times 8b signed tap
  always_ff @(posedge clk) begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        prod_p0[r][c] <= 17'($signed({{(9-CW){1'b0}}, pix[r][c]})) * 17'($signed(coef[r][c]));
      end
    end
  end

  always_comb begin
    acc = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        acc = acc + 21'(prod_p0[r][c]);
      end
    end
  end

  // S2: 21b signed accumulation
  always_ff @(posedge clk) begin
    sum_p1 <= acc;
  end

  always_comb begin
    shd    = sum_p1 >>> sh_p1;
    biased = 22'(shd) + 22'(off_p1);
  end

  // S3: clamped result, held while no valid pixel arrives
  always_ff @(posedge clk) begin
    if (rst)
      q_p2 <= '0;
    else if (vld_p1)
      q_p2 <= clamp(biased);
  end

endmodule

// File: rtl/convolution_engine.sv
// 3x3 RGB565 convolution: per-frame kernel shadow, three channel pipes, count delay line.
module convolution_engine
  import conv_pkg::*;
#(
  parameter int HRES = 320,
  parameter int VRES = 180
) (
  input  logic   clk_in,
  input  logic   rst_in,
  conv_if.slave  bus
);

  localparam int HW = $clog2(HRES);
  localparam int VW = $clog2(VRES);

  function automatic logic [3:0] eff_shift(input logic signed [7:0] s);
    if (s[7])
      return 4'd0;
    else if (s > 8'(MAX_SHIFT))
      return 4'(MAX_SHIFT);
    else
      return s[3:0];
  endfunction

  kernel_t            coef_sh;
  logic signed [7:0]  shift_sh;
  logic signed [7:0]  off_sh;

  logic               frame_start;
  kernel_t            coef_eff;
  logic signed [7:0]  shift_eff;
  logic signed [7:0]  off_eff;

  logic               vld_p0, vld_p1, vld_p2;
  logic [HW-1:0]      hc_p0, hc_p1, hc_p2;
  logic [VW-1:0]      vc_p0, vc_p1, vc_p2;
  logic [3:0]         sh_p0, sh_p1;
  logic signed [7:0]  off_p0, off_p1;

  logic [2:0][2:0][4:0] r_pix, b_pix;
  logic [2:0][2:0][5:0] g_pix;
  logic [4:0]           r_p2, b_p2;
  logic [5:0]           g_p2;

  // The first pixel of a frame sees its new kernel directly; the shadow serves the rest.
  always_comb begin
    frame_start = bus.data_in_valid && (bus.hcount_in == '0) && (bus.vcount_in == '0);
    coef_eff    = frame_start ? bus.coeffs_in : coef_sh;
    shift_eff   = frame_start ? bus.shift_in  : shift_sh;
    off_eff     = frame_start ? bus.offset_in : off_sh;
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        r_pix[r][c] = bus.data_in[r][c][15:11];
        g_pix[r][c] = bus.data_in[r][c][10:5];
        b_pix[r][c] = bus.data_in[r][c][4:0];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      coef_sh  <= '0;
      shift_sh <= '0;
      off_sh   <= '0;
      vld_p0   <= 1'b0;
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      hc_p0    <= '0;
      hc_p1    <= '0;
      hc_p2    <= '0;
      vc_p0    <= '0;
      vc_p1    <= '0;
      vc_p2    <= '0;
    end else begin
      if (frame_start) begin
        coef_sh  <= bus.coeffs_in;
        shift_sh <= bus.shift_in;
        off_sh   <= bus.offset_in;
      end
      // S1
      vld_p0 <= bus.data_in_valid;
      if (bus.data_in_valid) begin
        hc_p0 <= bus.hcount_in;
        vc_p0 <= bus.vcount_in;
      end
      // S2
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        hc_p1 <= hc_p0;
        vc_p1 <= vc_p0;
      end
      // S3
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        hc_p2 <= hc_p1;
        vc_p2 <= vc_p1;
      end
    end
  end

  // S1/S2: effective shift and bias follow their pixel down the pipe
  always_ff @(posedge clk_in) begin
    sh_p0  <= eff_shift(shift_eff);
    off_p0 <= off_eff;
    sh_p1  <= sh_p0;
    off_p1 <= off_p0;
  end

  conv_channel #(.CW(5), .MAXV(R_MAX)) u_red (
    .clk    (clk_in),
    .rst    (rst_in),
    .vld_p1 (vld_p1),
    .pix    (r_pix),
    .coef   (coef_eff),
    .sh_p1  (sh_p1),
    .off_p1 (off_p1),
    .q_p2   (r_p2)
  );

  conv_channel #(.CW(6), .MAXV(G_MAX)) u_green (
    .clk    (clk_in),
    .rst    (rst_in),
    .vld_p1 (vld_p1),
    .pix    (g_pix),
    .coef   (coef_eff),
    .sh_p1  (sh_p1),
    .off_p1 (off_p1),
    .q_p2   (g_p2)
  );

  conv_channel #(.CW(5), .MAXV(B_MAX)) u_blue (
    .clk    (clk_in),
    .rst    (rst_in),
    .vld_p1 (vld_p1),
    .pix    (b_pix),
    .coef   (coef_eff),
    .sh_p1  (sh_p1),
    .off_p1 (off_p1),
    .q_p2   (b_p2)
  );

  assign bus.data_out_valid = vld_p2;
  assign bus.data_out       = {r_p2, g_p2, b_p2};
  assign bus.hcount_out     = hc_p2;
  assign bus.vcount_out     = vc_p2;

endmodule

// File: tb/tb_convolution_engine.sv
// Scoreboard bench for convolution_engine: directed windows, queued expectations, negedge monitor.
module tb_convolution_engine;
  import conv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_if #(.HRES(320), .VRES(180)) bus ();

  convolution_engine #(.HRES(320), .VRES(180)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  typedef struct {
    logic [15:0] d;
    logic [8:0]  h;
    logic [7:0]  v;
    int          due;
    string       name;
  } exp_t;

  exp_t        sb [$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  logic        rst_q  = 1'b1;
  logic [15:0] last_d = '0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Monitor: decoupled from stimulus, pops on every valid output
  always @(negedge clk) begin
    exp_t e;
    if (rst_q) begin
      check("rst_valid", 32'(bus.data_out_valid), 32'd0);
      check("rst_data",  32'(bus.data_out),       32'd0);
      check("rst_hcount", 32'(bus.hcount_out),    32'd0);
      check("rst_vcount", 32'(bus.vcount_out),    32'd0);
      last_d = '0;
    end else if (bus.data_out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 32'(bus.data_out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check({e.name, "_data"},    32'(bus.data_out),   32'(e.d));
        check({e.name, "_hcount"},  32'(bus.hcount_out), 32'(e.h));
        check({e.name, "_vcount"},  32'(bus.vcount_out), 32'(e.v));
        check({e.name, "_latency"}, 32'(cyc),            32'(e.due));
        last_d = e.d;
      end
    end else begin
      check("hold_data", 32'(bus.data_out), 32'(last_d));
    end
  end

  function automatic window_t uni(input logic [15:0] p);
    window_t w;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[r][c] = p;
    return w;
  endfunction

  function automatic window_t ctr(input logic [15:0] p, input logic [15:0] bg);
    window_t w;
    w = uni(bg);
    w[1][1] = p;
    return w;
  endfunction

  function automatic window_t cols(input logic [15:0] l, input logic [15:0] m, input logic [15:0] rt);
    window_t w;
    for (int r = 0; r < 3; r++) begin
      w[r][0] = l;
      w[r][1] = m;
      w[r][2] = rt;
    end
    return w;
  endfunction

  function automatic kernel_t mk_k(input int a, input int b, input int c, input int d,
                                   input int e, input int f, input int g, input int h, input int i);
    kernel_t k;
    int t [9];
    t = '{a, b, c, d, e, f, g, h, i};
    for (int r = 0; r < 3; r++)
      for (int cc = 0; cc < 3; cc++)
        k[r][cc] = 8'(t[r*3 + cc]);
    return k;
  endfunction

  // Drives one window for one clock; optionally queues the expected pixel.
  task automatic send(input window_t w, input kernel_t k, input int sh, input int off,
                      input int h, input int v, input logic [15:0] d, input bit push,
                      input bit r, input string nm);
    rst               = r;
    bus.data_in_valid = 1'b1;
    bus.data_in       = w;
    bus.coeffs_in     = k;
    bus.shift_in      = 8'(sh);
    bus.offset_in     = 8'(off);
    bus.hcount_in     = 9'(h);
    bus.vcount_in     = 8'(v);
    if (push) sb.push_back('{d, 9'(h), 8'(v), cyc + 3, nm});
    @(posedge clk);
    #1;
    bus.data_in_valid = 1'b0;
    rst               = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    kernel_t k_id, k_zero, k_g, k_s, k_sx, k2, k127;
    int      w;
    k_id   = mk_k(0, 0, 0, 0, 1, 0, 0, 0, 0);
    k_zero = mk_k(0, 0, 0, 0, 0, 0, 0, 0, 0);
    k_g    = mk_k(1, 2, 1, 2, 4, 2, 1, 2, 1);
    k_s    = mk_k(0, -1, 0, -1, 5, -1, 0, -1, 0);
    k_sx   = mk_k(1, 0, -1, 2, 0, -2, 1, 0, -1);
    k2     = mk_k(0, 0, 0, 0, 2, 0, 0, 0, 0);
    k127   = mk_k(127, 127, 127, 127, 127, 127, 127, 127, 127);

    bus.data_in_valid = 1'b0;
    bus.data_in       = '0;
    bus.coeffs_in     = '0;
    bus.shift_in      = '0;
    bus.offset_in     = '0;
    bus.hcount_in     = '0;
    bus.vcount_in     = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    send(ctr(16'hF81F, 16'h1234), k_id,   0, 0, 0, 0, 16'hF81F, 1, 0, "t1_identity");
    send(ctr(16'hABCD, 16'h0000), k_zero, 0, 0, 1, 0, 16'hABCD, 1, 0, "t1_shadow");
    idle(5);

    send(uni(16'h07E0), k_g, 4, 0, 0, 0, 16'h07E0, 1, 0, "t2_blur_green");
    send(uni(16'h8410), k_g, 4, 0, 0, 0, 16'h8410, 1, 0, "t2_blur_mid");
    send(uni(16'hFFFF), k_g, 4, 0, 0, 0, 16'hFFFF, 1, 0, "t2_blur_white");
    send(ctr(16'hF800, 16'h0000), k_s, 0, 16, 0, 0, 16'hFA10, 1, 0, "t3_sharpen_clamp");
    send(uni(16'h0000),           k_s, 0, 16, 0, 0, 16'h8210, 1, 0, "t3_sharpen_offset");
    send(ctr(16'h0000, 16'hFFFF), k_s, 0, 16, 0, 0, 16'h0000, 1, 0, "t3_sharpen_neg");
    send(ctr(16'h2800, 16'h0000), k2,   -3, 0, 0, 0, 16'h5000, 1, 0, "shift_negative");
    send(uni(16'hFFFF),           k127, 20, 0, 0, 0, 16'h0841, 1, 0, "shift_saturate");
    send(ctr(16'hFFFF, 16'h0000), k_id, 0, -8, 0, 0, 16'hBEF7, 1, 0, "offset_negative");
    send(cols(16'hFFFF, 16'h0000, 16'h0000), k_sx, 0, 0, 0, 0, 16'hFFFF, 1, 0, "t4_sobel_pos");
    send(cols(16'h0000, 16'h0000, 16'hFFFF), k_sx, 0, 0, 0, 0, 16'h0000, 1, 0, "t4_sobel_neg");
    idle(5);

    send(ctr(16'h1234, 16'h0000), k_id, 0, 0, 0,   0, 16'h1234, 1, 0, "t5_frame");
    send(ctr(16'h5555, 16'h0000), k_g,  4, 0, 100, 5, 16'h5555, 1, 0, "t5_midframe");
    send(ctr(16'h8410, 16'h0000), k_g,  4, 0, 0,   0, 16'h2104, 1, 0, "t5_newframe");
    send(ctr(16'h8410, 16'h0000), k_id, 0, 0, 1,   0, 16'h2104, 1, 0, "t5_after");
    idle(6);

    send(ctr(16'hFFFF, 16'h0000), k_id, 0, 0, 3, 1, 16'h0000, 0, 0, "t6_flushed_a");
    send(ctr(16'hFFFF, 16'h0000), k_id, 0, 0, 4, 1, 16'h0000, 0, 0, "t6_flushed_b");
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    send(ctr(16'hFFFF, 16'h0000), k_id, 0, 0, 7, 3, 16'h0000, 1, 0, "t6_post_rst");
    idle(5);

    send(ctr(16'hFFFF, 16'h0000), k_id, 0, 0, 0, 0, 16'h0000, 0, 1, "t6_rst_cycle");
    send(ctr(16'hFFFF, 16'h0000), k_id, 0, 0, 2, 0, 16'h0000, 1, 0, "t6_rst_valid");
    send(ctr(16'hFFFF, 16'h0000), k_id, 0, 0, 0, 0, 16'hFFFF, 1, 0, "t6_recover");

    w = 0;
    while (sb.size() != 0 && w < 50) begin
      @(posedge clk);
      w++;
    end
    repeat (2) @(negedge clk);
    check("drain_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
